// File: rtl/ddr_read_arbiter.sv
// ddr_read_arbiter
// Two-port read arbiter in front of a DDR controller. Port 0 (display fetch)
// normally wins; port 1 (drawing engine) is forced through after
// STARVE_LIMIT consecutive port-0 wins while it was waiting. All handshakes
// (both requesters and the DDR controller) are 4-phase req/ack. A read that
// is never acknowledged is abandoned after TIMEOUT cycles, the requester is
// still completed (with its old data) and a sticky error flag is raised.
module ddr_read_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [23:0] addr0,
   output logic        ack0,
   output logic [15:0] data0,
   input  logic        req1,
   input  logic [23:0] addr1,
   output logic        ack1,
   output logic [15:0] data1,
   output logic        ddrRead,
   output logic [23:0] ddrReadAddress,
   input  logic        ddrReadAcknowledge,
   input  logic [15:0] ddrReadData,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        timeoutError
);

   localparam int               WAIT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [2:0]        STARVE_MAX = 3'(STARVE_LIMIT);
   localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RELEASE,
      S_RESPOND
   } state_t;

   state_t            state_q;
   logic [1:0]        grant_q;
   logic [1:0]        ack_q;
   logic              ddr_read_q;
   logic [23:0]       ddr_addr_q;
   logic              busy_q;
   logic              timeout_q;
   logic [2:0]        starve_q;
   logic [WAIT_W-1:0] wait_q;

   logic              pick1_d;
   logic [2:0]        starve_d;
   logic [WAIT_W-1:0] wait_d;
   logic              wait_done_d;
   logic              granted_req_d;
   logic [1:0]        req_v;
   logic [1:0]        capture_v;

   assign req_v = {req1, req0};

   // Arbitration decision, starvation bookkeeping and ISSUE wait counting
   always_comb begin
      pick1_d  = req1 && (!req0 || (starve_q >= STARVE_MAX));
      starve_d = starve_q;
      if (pick1_d) begin
         starve_d = '0;
      end else if (req0 && req1 && (starve_q < STARVE_MAX)) begin
         starve_d = starve_q + 3'd1;
      end
      wait_d        = wait_q + WAIT_W'(1);
      wait_done_d   = (wait_d == WAIT_MAX);
      granted_req_d = |(grant_q & req_v);
   end

   // A port's data register loads only when the DDR acknowledges its read
   assign capture_v = (state_q == S_ISSUE && ddrReadAcknowledge) ? grant_q : 2'b00;

   // Arbiter FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         ack_q      <= '0;
         ddr_read_q <= 1'b0;
         ddr_addr_q <= '0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         starve_q   <= '0;
         wait_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Addresses are sampled only here; later changes are ignored
               if (req0 || req1) begin
                  grant_q    <= pick1_d ? 2'b10 : 2'b01;
                  ddr_addr_q <= pick1_d ? addr1 : addr0;
                  ddr_read_q <= 1'b1;
                  busy_q     <= 1'b1;
                  wait_q     <= '0;
                  starve_q   <= starve_d;
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // A withdrawn request does not abort the read in flight
               if (ddrReadAcknowledge) begin
                  ddr_read_q <= 1'b0;
                  state_q    <= S_RELEASE;
               end else if (wait_done_d) begin
                  ddr_read_q <= 1'b0;
                  timeout_q  <= 1'b1;
                  state_q    <= S_RELEASE;
               end else begin
                  wait_q <= wait_d;
               end
            end
            S_RELEASE: begin
               // Finish the DDR handshake before answering the requester
               if (!ddrReadAcknowledge) begin
                  ack_q   <= grant_q;
                  state_q <= S_RESPOND;
               end
            end
            S_RESPOND: begin
               // ack is always seen for at least one cycle
               if (!granted_req_d) begin
                  ack_q   <= '0;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Per-port read data registers, holding their value between reads
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [15:0] data_q;

         // Load read data when this port's DDR read is acknowledged
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_q <= '0;
            end else if (capture_v[gi]) begin
               data_q <= ddrReadData;
            end
         end
      end
   endgenerate

   assign data0          = g_port[0].data_q;
   assign data1          = g_port[1].data_q;
   assign ack0           = ack_q[0];
   assign ack1           = ack_q[1];
   assign ddrRead        = ddr_read_q;
   assign ddrReadAddress = ddr_addr_q;
   assign grant          = grant_q;
   assign busy           = busy_q;
   assign timeoutError   = timeout_q;

endmodule
